// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - handshake bundle for the immediate extender (out_count under IMM_EXT_CNT_EN)
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_len;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
`ifdef IMM_EXT_CNT_EN
    logic [15:0]      out_count;
`endif

    modport master (
        output in_valid, in_imm, in_len, in_mode, out_ready,
        input  in_ready, out_valid, out_data
`ifdef IMM_EXT_CNT_EN
        , input out_count
`endif
    );

    modport slave (
        input  in_valid, in_imm, in_len, in_mode, out_ready,
        output in_ready, out_valid, out_data
`ifdef IMM_EXT_CNT_EN
        , output out_count
`endif
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - skid + two-stage immediate extender; IMM_EXT_CNT_EN adds an output handshake counter
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst,
    imm_extend_pipe_if.slave   bus
);
    typedef struct packed {
        logic [IN_W-1:0] imm;
        logic [1:0]      len;
        logic [1:0]      mode;
    } beat_t;

    beat_t            in_beat;
    beat_t            skid_q, skid_d, s1_q, s1_d;
    logic             skid_valid_q, skid_valid_d;
    logic             s1_valid_q, s1_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [OUT_W-1:0] sext, zext, ext;
    logic             accept, s2_adv, s1_load;

    assign in_beat = '{imm: bus.in_imm, len: bus.in_len, mode: bus.in_mode};

    always_comb begin
        accept       = bus.in_valid & in_ready_q;
        s2_adv       = s1_valid_q & (~out_valid_q | bus.out_ready);
        s1_load      = ~s1_valid_q | s2_adv;
        s1_valid_d   = s1_load ? (skid_valid_q | accept) : s1_valid_q;
        s1_d         = s1_load ? (skid_valid_q ? skid_q : in_beat) : s1_q;
        // The skid only catches a beat when S1 is stuck; in_ready already hides it otherwise
        skid_valid_d = skid_valid_q ? ~s1_load : (accept & ~s1_load);
        skid_d       = (accept & ~s1_load) ? in_beat : skid_q;
        in_ready_d   = ~skid_valid_d;
        out_valid_d  = s2_adv | (out_valid_q & ~bus.out_ready);
        out_data_d   = s2_adv ? ext : out_data_q;
    end

    always_comb begin
        sext = '0;
        zext = '0;
        case (s1_q.len)
            2'b00: begin
                sext = {{(OUT_W-4){s1_q.imm[3]}}, s1_q.imm[3:0]};
                zext = {{(OUT_W-4){1'b0}}, s1_q.imm[3:0]};
            end
            2'b01: begin
                sext = {{(OUT_W-8){s1_q.imm[7]}}, s1_q.imm[7:0]};
                zext = {{(OUT_W-8){1'b0}}, s1_q.imm[7:0]};
            end
            2'b10: begin
                sext = {{(OUT_W-12){s1_q.imm[11]}}, s1_q.imm[11:0]};
                zext = {{(OUT_W-12){1'b0}}, s1_q.imm[11:0]};
            end
            default: begin
                sext = {{(OUT_W-IN_W){s1_q.imm[IN_W-1]}}, s1_q.imm};
                zext = {{(OUT_W-IN_W){1'b0}}, s1_q.imm};
            end
        endcase
        case (s1_q.mode)
            2'b00:   ext = sext;
            2'b01:   ext = zext;
            2'b10:   ext = {s1_q.imm, {(OUT_W-IN_W){1'b0}}};
            default: ext = sext << BR_SHIFT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

`ifdef IMM_EXT_CNT_EN
    logic [15:0] out_count_q, out_count_d;

    assign out_count_d = (out_valid_q & bus.out_ready) ? out_count_q + 16'd1 : out_count_q;

    always_ff @(posedge clk) begin
        if (rst) out_count_q <= '0;
        else     out_count_q <= out_count_d;
    end

    assign bus.out_count = out_count_q;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed bench with scoreboard model for imm_extend_pipe (IMM_EXT_CNT_EN aware)
module tb_imm_extend_pipe;
    localparam int IN_W     = 16;
    localparam int OUT_W    = 32;
    localparam int BR_SHIFT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .BR_SHIFT(BR_SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    logic [OUT_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result from plain integer arithmetic on the field value
    function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] imm, input logic [1:0] len,
                                               input logic [1:0] mode);
        int     l;
        longint f, s;
        l = (len == 2'd0) ? 4 : (len == 2'd1) ? 8 : (len == 2'd2) ? 12 : IN_W;
        f = longint'(imm) & ((longint'(1) << l) - 1);
        s = (f >= (longint'(1) << (l - 1))) ? f - (longint'(1) << l) : f;
        case (mode)
            2'd0:    return OUT_W'(s);
            2'd1:    return OUT_W'(f);
            2'd2:    return OUT_W'(longint'(imm) * (longint'(1) << (OUT_W - IN_W)));
            default: return OUT_W'(s * (longint'(1) << BR_SHIFT));
        endcase
    endfunction

    initial begin : monitor
        logic             prev_stall;
        logic [OUT_W-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
                hs_count   = 0;
            end else begin
                if (prev_stall)
                    check("hold_while_stalled", {bus.out_valid, bus.out_data}, {1'b1, prev_data});
`ifdef IMM_EXT_CNT_EN
                check("out_count", bus.out_count, 16'(hs_count));
`endif
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) check("spurious_output", 1, 0);
                    else                   check("out_data_order", bus.out_data, exp_q.pop_front());
                    hs_count++;
                end
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(model(bus.in_imm, bus.in_len, bus.in_mode));
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    task automatic push(input logic [IN_W-1:0] imm, input logic [1:0] len, input logic [1:0] mode,
                        output int waits);
        logic ok;
        bus.in_valid = 1'b1;
        bus.in_imm   = imm;
        bus.in_len   = len;
        bus.in_mode  = mode;
        waits = 0;
        while (1) begin
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waits++;
            if (waits > 50) begin
                check("push_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic single(input string name, input logic [IN_W-1:0] imm, input logic [1:0] len,
                          input logic [1:0] mode, input logic [OUT_W-1:0] exp);
        int w;
        push(imm, len, mode, w);
        check({name, "_not_yet"}, bus.out_valid, 0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, bus.out_valid, 1);
        check({name, "_data"}, bus.out_data, exp);
    endtask

    initial begin : stim
        int w, n, hs0, tot;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_len    = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;

        check("model_sext16",   model(16'hFFFF, 2'd3, 2'd0), 32'hFFFFFFFF);
        check("model_zext16",   model(16'h8001, 2'd3, 2'd1), 32'h00008001);
        check("model_sext8",    model(16'h12F0, 2'd1, 2'd0), 32'hFFFFFFF0);
        check("model_upper",    model(16'h1234, 2'd0, 2'd2), 32'h12340000);
        check("model_branch16", model(16'hFFFF, 2'd3, 2'd3), 32'hFFFFFFFC);
        check("model_branch12", model(16'h07FF, 2'd2, 2'd3), 32'h00001FFC);

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
`ifdef IMM_EXT_CNT_EN
        check("rst_out_count", bus.out_count, 0);
`endif
        rst = 1'b0;

        single("sext16",   16'hFFFF, 2'd3, 2'd0, 32'hFFFFFFFF);
        single("zext16",   16'h8001, 2'd3, 2'd1, 32'h00008001);
        single("sext8",    16'h12F0, 2'd1, 2'd0, 32'hFFFFFFF0);
        single("upper",    16'h1234, 2'd0, 2'd2, 32'h12340000);
        single("branch16", 16'hFFFF, 2'd3, 2'd3, 32'hFFFFFFFC);
        single("branch12", 16'h07FF, 2'd2, 2'd3, 32'h00001FFC);
        single("sext4_pos", 16'hFFF7, 2'd0, 2'd0, 32'h00000007);
        single("zext12",   16'hFABC, 2'd2, 2'd1, 32'h00000ABC);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b0;
        push(16'h1, 2'd3, 2'd0, w);
        push(16'h2, 2'd3, 2'd0, w);
        push(16'h3, 2'd3, 2'd0, w);
        check("bp_in_ready_low", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h4;
        repeat (2) @(posedge clk);
        #1;
        check("bp_still_full", bus.in_ready, 0);
        check("bp_head", bus.out_data, 32'h1);
        bus.out_ready = 1'b1;
        n = 0;
        fork
            push(16'h4, 2'd3, 2'd0, w);
            begin
                repeat (4) begin
                    @(negedge clk);
                    if (bus.out_valid && bus.out_ready) n++;
                end
            end
        join
        check("bp_drain_consecutive", n, 4);
        @(posedge clk);
        #1;
        check("bp_in_ready_back", bus.in_ready, 1);
        check("bp_queue_empty", exp_q.size(), 0);

        hs0 = hs_count;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            push(16'(16'h1357 * (i + 1) + 16'h8000 * (i % 2)), 2'(i / 2), 2'(i % 4), w);
            tot += w;
        end
        check("stream_no_stall", tot, 0);
        repeat (2) @(posedge clk);
        #1;
        check("stream_results", hs_count - hs0, 8);

        bus.out_ready = 1'b0;
        push(16'hAAAA, 2'd3, 2'd0, w);
        push(16'h5555, 2'd3, 2'd1, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_data", bus.out_data, 0);
`ifdef IMM_EXT_CNT_EN
        check("mid_rst_out_count", bus.out_count, 0);
`endif
        bus.out_ready = 1'b1;
        n = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) n++;
        end
        check("mid_rst_no_stale", n, 0);

        single("post_rst", 16'h0080, 2'd1, 2'd3, 32'hFFFFFE00);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
